// File: rtl/sig_pkg.sv
// Shared definitions for the pulse decoder: FSM states, bit values, default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sig_pkg;

    // Decoder FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } dec_state_t;

    // Bit values produced by mark classification
    localparam logic BIT_SHORT = 1'b0;
    localparam logic BIT_LONG  = 1'b1;

    // Default sizing
    localparam int DEF_WORD_BITS   = 8;
    localparam int DEF_LONG_CYCLES = 8;
    localparam int DEF_GAP_CYCLES  = 16;

endpackage

// File: rtl/sig_dec_out_reg.sv
// Output holding register with valid/ready handshake and sticky drop flag.
// Latency: a close strobe is visible on out_* one cycle later (registered).
// Backpressure: loads only if empty or being accepted this cycle; otherwise drops and sets ovf.
module sig_dec_out_reg #(
    parameter int WORD_BITS = 8,
    parameter int LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 close_vld,
    input  logic [WORD_BITS-1:0] close_dat,
    input  logic [LEN_W-1:0]     close_len,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WORD_BITS-1:0] out_data,
    output logic [LEN_W-1:0]     out_len,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    logic load;

    // A slot is free when empty or when the current word leaves this same cycle
    assign load = close_vld && (!out_valid || out_ready);

    // Holding register: reload has priority over plain acceptance, so no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= close_dat;
            out_len   <= close_len;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky drop flag: a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (close_vld && !load) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/sig_pulse_decoder.sv
// Times marks after the detector strobe, classifies SHORT/LONG, packs bits into words.
// Latency: word visible one cycle after the closing fall edge or gap-timeout cycle.
// Backpressure: single holding register; words closed while it is full are dropped (ovf).
// Optional SIG_DEC_EVT_CNT_EN adds evt_cnt, a wrapping count of accepted strobes.
module sig_pulse_decoder
    import sig_pkg::*;
#(
    parameter int WORD_BITS   = DEF_WORD_BITS,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sig,
    input  logic                           det_valid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_BITS-1:0]           out_data,
    output logic [$clog2(WORD_BITS+1)-1:0] out_len,
    output logic                           ovf,
    input  logic                           ovf_clr
`ifdef SIG_DEC_EVT_CNT_EN
    ,
    output logic [15:0]                    evt_cnt
`endif
);

    localparam int LEN_W  = $clog2(WORD_BITS + 1);
    localparam int HCNT_W = $clog2(LONG_CYCLES + 1);
    localparam int GCNT_W = $clog2(GAP_CYCLES);

    localparam logic [LEN_W-1:0]  BCNT_FULL = LEN_W'(WORD_BITS);
    localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(LONG_CYCLES);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);

    dec_state_t           state, state_nxt;
    logic [HCNT_W-1:0]    hcnt, hcnt_nxt;
    logic [GCNT_W-1:0]    gcnt, gcnt_nxt, gcnt_inc;
    logic [LEN_W-1:0]     bcnt, bcnt_nxt, bcnt_inc;
    logic [WORD_BITS-1:0] shreg, shreg_nxt, shreg_shift;
    logic                 mark_bit;

    logic                 close_vld;
    logic [WORD_BITS-1:0] close_dat;
    logic [LEN_W-1:0]     close_len;

    // Classification and the candidate shift/count values used on a fall edge
    always_comb begin
        mark_bit    = (hcnt >= HCNT_SAT) ? BIT_LONG : BIT_SHORT;
        shreg_shift = {shreg[WORD_BITS-2:0], mark_bit};
        bcnt_inc    = bcnt + LEN_W'(1);
        gcnt_inc    = gcnt + GCNT_W'(1);
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hcnt  <= '0;
            gcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            gcnt  <= gcnt_nxt;
            bcnt  <= bcnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Next-state, counter updates and word-close strobe
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        gcnt_nxt  = gcnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        close_vld = 1'b0;
        close_dat = shreg;
        close_len = bcnt;
        case (state)
            ST_IDLE: begin
                if (det_valid) begin
                    state_nxt = ST_MARK;
                    hcnt_nxt  = HCNT_W'(1);
                end
            end
            ST_MARK: begin
                // Strobes during a mark are ignored; only sig matters here
                if (sig) begin
                    if (hcnt != HCNT_SAT) begin
                        hcnt_nxt = hcnt + HCNT_W'(1);
                    end
                end else if (bcnt_inc == BCNT_FULL) begin
                    close_vld = 1'b1;
                    close_dat = shreg_shift;
                    close_len = bcnt_inc;
                    shreg_nxt = '0;
                    bcnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    shreg_nxt = shreg_shift;
                    bcnt_nxt  = bcnt_inc;
                    gcnt_nxt  = '0;
                    state_nxt = ST_SPACE;
                end
            end
            ST_SPACE: begin
                // A new mark beats the timeout when both land in the same cycle.
                // The fall cycle is the first low cycle, so the gap closes when
                // the incremented count reaches GAP_CYCLES-1.
                if (det_valid) begin
                    state_nxt = ST_MARK;
                    hcnt_nxt  = HCNT_W'(1);
                end else if (gcnt_inc == GCNT_LAST) begin
                    close_vld = 1'b1;
                    close_dat = shreg;
                    close_len = bcnt;
                    shreg_nxt = '0;
                    bcnt_nxt  = '0;
                    gcnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    gcnt_nxt = gcnt_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    sig_dec_out_reg #(
        .WORD_BITS (WORD_BITS),
        .LEN_W     (LEN_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .close_vld (close_vld),
        .close_dat (close_dat),
        .close_len (close_len),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_len   (out_len),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

`ifdef SIG_DEC_EVT_CNT_EN
    logic evt_acc;

    // Strobes only count where the FSM acts on them
    assign evt_acc = det_valid && ((state == ST_IDLE) || (state == ST_SPACE));

    // Wrapping accepted-strobe counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (evt_acc) begin
            evt_cnt <= evt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sig_pulse_decoder.sv
module tb_sig_pulse_decoder;

    logic       clk;
    logic       rst_n;
    logic       sig;
    logic       det_valid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_len;
    logic       ovf;
    logic       ovf_clr;
`ifdef SIG_DEC_EVT_CNT_EN
    logic [15:0] evt_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    sig_pulse_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig       (sig),
        .det_valid (det_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef SIG_DEC_EVT_CNT_EN
        ,
        .evt_cnt   (evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One word: n marks, holds[n-1] is the first mark sent
    typedef struct packed {
        logic [3:0]      n;
        logic [7:0][4:0] holds;
        logic [4:0]      gap;
        logic [7:0]      exp_data;
        logic [3:0]      exp_len;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe cycle counts as hold 1; returns just after the fall-cycle edge
    task automatic do_mark(input int hold);
        det_valid = 1'b1;
        sig       = 1'b1;
        step();
        det_valid = 1'b0;
        repeat (hold - 1) step();
        sig = 1'b0;
        step();
        strobes++;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{n: 4'd8, holds: {8{5'd3}}, gap: 5'd4, exp_data: 8'h00, exp_len: 4'd8};
        vecs[1] = '{n: 4'd3, holds: {5'd10, 5'd3, 5'd10}, gap: 5'd4, exp_data: 8'h05, exp_len: 4'd3};
        vecs[2] = '{n: 4'd1, holds: {5'd7}, gap: 5'd4, exp_data: 8'h00, exp_len: 4'd1};
        vecs[3] = '{n: 4'd1, holds: {5'd8}, gap: 5'd4, exp_data: 8'h01, exp_len: 4'd1};
        vecs[4] = '{n: 4'd8, holds: {5'd8, 5'd7, 5'd8, 5'd7, 5'd8, 5'd7, 5'd8, 5'd7},
                    gap: 5'd3, exp_data: 8'hAA, exp_len: 4'd8};
        vecs[5] = '{n: 4'd2, holds: {5'd20, 5'd1}, gap: 5'd5, exp_data: 8'h02, exp_len: 4'd2};
        vecs[6] = '{n: 4'd4, holds: {5'd9, 5'd2, 5'd2, 5'd12}, gap: 5'd2, exp_data: 8'h09, exp_len: 4'd4};

        rst_n     = 1'b0;
        sig       = 1'b0;
        det_valid = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) step();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_len", 32'(out_len), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven words
        for (int v = 0; v < 7; v++) begin
            for (int i = int'(vecs[v].n) - 1; i >= 0; i--) begin
                do_mark(int'(vecs[v].holds[i]));
                if (i != 0) repeat (int'(vecs[v].gap) - 1) step();
            end
            wait_valid();
            chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d out_data", v), 32'(out_data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d out_len", v), 32'(out_len), 32'(vecs[v].exp_len));
            chk($sformatf("vec%0d ovf", v), 32'(ovf), 32'd0);
            consume();
            chk($sformatf("vec%0d drained", v), 32'(out_valid), 32'd0);
        end

        // Gap timeout boundary: fall cycle plus 15 further low cycles close the word
        do_mark(10); repeat (3) step();
        do_mark(3);  repeat (3) step();
        do_mark(10);
        repeat (14) step();
        chk("gap 15 low not closed", 32'(out_valid), 32'd0);
        step();
        chk("gap 16 low closed", 32'(out_valid), 32'd1);
        chk("gap word data", 32'(out_data), 32'h05);
        chk("gap word len", 32'(out_len), 32'd3);
        consume();

        // Backpressure: first word held, second dropped
        do_mark(8);
        wait_valid();
        do_mark(3);
        repeat (20) step();
        chk("hold valid", 32'(out_valid), 32'd1);
        chk("hold data", 32'(out_data), 32'h01);
        chk("hold len", 32'(out_len), 32'd1);
        chk("drop ovf set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf cleared", 32'(ovf), 32'd0);

        // Drop and clear in the same cycle: set wins
        do_mark(3);
        repeat (14) step();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf set beats clr", 32'(ovf), 32'd1);
        chk("held data unchanged", 32'(out_data), 32'h01);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf cleared again", 32'(ovf), 32'd0);

        // Accept and reload in the same cycle: no bubble, no drop
        do_mark(9); repeat (3) step();
        do_mark(2);
        repeat (14) step();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("reload valid", 32'(out_valid), 32'd1);
        chk("reload data", 32'(out_data), 32'h02);
        chk("reload len", 32'(out_len), 32'd2);
        chk("reload no ovf", 32'(ovf), 32'd0);

        // Reset mid-mark after 4 bits, with a word still held
        for (int i = 0; i < 4; i++) begin
            do_mark(3);
            repeat (3) step();
        end
        det_valid = 1'b1; sig = 1'b1; step();
        det_valid = 1'b0; step(); step();
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_data", 32'(out_data), 32'd0);
        chk("async rst out_len", 32'(out_len), 32'd0);
        chk("async rst ovf", 32'(ovf), 32'd0);
        step();
        rst_n = 1'b1;
        strobes = 0;
        sig = 1'b0;
        repeat (40) step();
        chk("no word after reset", 32'(out_valid), 32'd0);
        do_mark(8);
        wait_valid();
        chk("post-reset word data", 32'(out_data), 32'h01);
        chk("post-reset word len", 32'(out_len), 32'd1);
        consume();

`ifdef SIG_DEC_EVT_CNT_EN
        chk("evt_cnt", 32'(evt_cnt), 32'(strobes[15:0]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
